pipe_stage_buffer: RTL and testbench
====================================

# pipe_stage_buffer

Parametrised pipeline stage register with valid/ready handshake, optional skid entry, synchronous flush and a stall counter. It generalises the fixed-field stage registers between CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) into one block. The block carries an opaque packed payload, so it sits between any two stages and supports hazard stalls and branch/exception flushes without per-stage logic.

## Interface
- DATA_W, 32: payload width in bits (packed instruction, control bits, ALU result, store data, ...).
- DEPTH, 2: 1 = single register, combinational in_ready; 2 = register plus skid entry, registered in_ready.
- BUBBLE_ZERO, 1: 1 forces out_data to 0 whenever out_valid=0, so control bits read as a bubble.
- CNT_W, 16: stall counter width.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream stage presents a payload.
- in_data  in  DATA_W  upstream payload.
- in_ready  out  1  block accepts the payload this cycle.
- out_valid  out  1  payload available to the downstream stage.
- out_data  out  DATA_W  downstream payload.
- out_ready  in  1  downstream consumes the payload this cycle.
- flush  in  1  synchronous kill of all held and incoming payloads.
- clr_cnt  in  1  synchronous clear of stall_cnt.
- stall_cnt  out  CNT_W  saturating count of cycles with out_valid=1 and out_ready=0.

## Operation
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- States: EMPTY, ONE (main register valid), TWO (main and skid valid; DEPTH=2 only).
- EMPTY: in_fire -> ONE, main <= in_data.
- ONE: in_fire & out_fire -> ONE, main <= in_data. in_fire only -> TWO, skid <= in_data (DEPTH=2). out_fire only -> EMPTY.
- TWO: in_ready=0. out_fire -> ONE, main <= skid.
- Payload order is strictly FIFO. Nothing is dropped or duplicated unless flush is asserted.
- out_valid = (state != EMPTY). out_data = main. With BUBBLE_ZERO=1 and state=EMPTY, out_data = 0. Otherwise out_data holds the last main value.
- DEPTH=1: in_ready = (state==EMPTY) | out_ready, combinational from out_ready.
- DEPTH=2: in_ready = (state != TWO), taken from a flop with no combinational path from out_ready.
- flush has priority over everything else. Next state is EMPTY, and any in_fire in the flush cycle is discarded. Data registers need not be cleared.
- stall_cnt increments by 1 each cycle with out_valid & !out_ready and saturates at 2^CNT_W-1. clr_cnt has priority and zeroes the counter. Flush does not clear the counter.
- An illegal DEPTH (not 1 or 2) is a configuration error and fails elaboration.

## Timing
- Reset (rst_n=0, asynchronous): state EMPTY, main=0, skid=0, out_valid=0, out_data=0, stall_cnt=0. in_ready=1 for both depths once rst_n=1. Release is synchronised by the top level.
- Latency: a payload accepted at edge N appears on out_data/out_valid after edge N, i.e. one cycle.
- Throughput: one payload per cycle with out_ready held at 1, for both depths.
- DEPTH=2 with out_ready low: accepts 2 payloads, then deasserts in_ready at the edge that fills skid.
- Flush at edge N: out_valid=0 after edge N. in_ready is 1 after edge N.
- Reset mid-operation discards all contents immediately, without waiting for a clock.

## Structure
- A shared pipeline package holds the state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) and the per-stage payload field widths and offsets used to pack and unpack DATA_W.
- One sub-module, sat_counter (CNT_W, inc, clr), implements stall_cnt.
- The data path (main/skid registers with muxing) and the state register stay in the top module.

## Test plan
- Reset: drive rst_n low mid-stream with 2 payloads held. Required: out_valid=0, out_data=0 and stall_cnt=0 before the next edge; in_ready=1 after release.
- Streaming, DEPTH=2: send 0x11..0x18 on 8 consecutive cycles with out_ready=1. Required: identical sequence at the output, one cycle later, no gaps, stall_cnt=0.
- Backpressure, DEPTH=2: out_ready=0, offer 0xA, 0xB, 0xC. Required: 0xA and 0xB accepted, in_ready=0 on the third cycle, 0xC held upstream. After out_ready=1, output is 0xA, 0xB, 0xC in order. stall_cnt equals the stalled cycle count.
- Flush with simultaneous input: state TWO, assert flush and in_valid=1 with 0xF. Required: out_valid=0 next cycle, 0xF never appears, BUBBLE_ZERO=1 gives out_data=0.
- DEPTH=1 combinational ready: state ONE, toggle out_ready 0/1. Required: in_ready follows out_ready in the same cycle, and a payload accepted with out_ready=1 replaces main.
- Counter saturation, CNT_W=4: stall 20 cycles. Required: stall_cnt=15. clr_cnt for one cycle gives 0, or 1 on the next edge if the stall continues.

Source files
------------

// File: rtl/pipe_stage_buffer_pkg.sv
// Shared pipeline definitions: stage-buffer state encoding and the default
// per-stage payload layout used to pack/unpack the opaque DATA_W payload.
package pipe_stage_buffer_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Default 32-bit stage payload: {imm, rd, ctrl}, ctrl in the low bits.
    localparam int STAGE_W  = 32;
    localparam int CTRL_W   = 8;
    localparam int CTRL_LSB = 0;
    localparam int RD_W     = 5;
    localparam int RD_LSB   = CTRL_LSB + CTRL_W;
    localparam int IMM_W    = 19;
    localparam int IMM_LSB  = RD_LSB + RD_W;

    function automatic logic [STAGE_W-1:0] pack_payload(
        input logic [CTRL_W-1:0] ctrl,
        input logic [RD_W-1:0]   rd,
        input logic [IMM_W-1:0]  imm
    );
        return {imm, rd, ctrl};
    endfunction

    function automatic logic [CTRL_W-1:0] payload_ctrl(input logic [STAGE_W-1:0] data);
        return data[CTRL_LSB +: CTRL_W];
    endfunction

    function automatic logic [RD_W-1:0] payload_rd(input logic [STAGE_W-1:0] data);
        return data[RD_LSB +: RD_W];
    endfunction

    function automatic logic [IMM_W-1:0] payload_imm(input logic [STAGE_W-1:0] data);
        return data[IMM_LSB +: IMM_W];
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != CNT_MAX)) begin
            count <= count + CNT_ONE;
        end
    end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Generic pipeline stage register with valid/ready handshake, optional skid
// entry, synchronous flush and a saturating stall counter.
module pipe_stage_buffer
    import pipe_stage_buffer_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int DEPTH       = 2,
    parameter int BUBBLE_ZERO = 1,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    input  logic              flush,
    input  logic              clr_cnt,
    output logic [CNT_W-1:0]  stall_cnt
);

    if ((DEPTH != 1) && (DEPTH != 2)) begin : g_bad_depth
        $error("pipe_stage_buffer: DEPTH must be 1 or 2");
    end

    // Handshake: a payload moves when valid and ready are both high at the
    // rising edge; valid never depends on ready from the same side.
    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] main_q;
    logic [DATA_W-1:0] skid_q;
    logic              in_fire;
    logic              out_fire;
    logic              load_main_in;
    logic              load_main_skid;
    logic              load_skid;

    assign out_valid = (state != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    assign out_data  = ((BUBBLE_ZERO != 0) && !out_valid) ? '0 : main_q;

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        state_nxt    = ONE;
                        load_main_in = 1'b1;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        load_main_in = 1'b1;
                    end else if (in_fire && (DEPTH == 2)) begin
                        state_nxt = TWO;
                        load_skid = 1'b1;
                    end else if (out_fire) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        state_nxt      = ONE;
                        load_main_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (load_main_in) begin
                main_q <= in_data;
            end else if (load_main_skid) begin
                main_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= in_data;
            end
        end
    end

    if (DEPTH == 1) begin : g_ready_comb
        assign in_ready = (state == EMPTY) | out_ready;
    end else begin : g_ready_reg
        // Registered so upstream sees no combinational path from out_ready.
        logic ready_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ready_q <= 1'b1;
            end else begin
                ready_q <= (state_nxt != TWO);
            end
        end
        assign in_ready = ready_q;
    end

    sat_counter #(
        .CNT_W(CNT_W)
    ) u_stall_cnt (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (out_valid & ~out_ready),
        .clr  (clr_cnt),
        .count(stall_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Bench for pipe_stage_buffer: a DEPTH=2 and a DEPTH=1/CNT_W=4 instance share
// stimulus; each is compared every cycle with a queue-based reference model.
module tb_pipe_stage_buffer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_data;
    logic        out_ready;
    logic        flush;
    logic        clr_cnt;

    logic        in_ready2, out_valid2;
    logic [31:0] out_data2;
    logic [15:0] stall_cnt2;
    logic        in_ready1, out_valid1;
    logic [31:0] out_data1;
    logic [3:0]  stall_cnt1;

    int checks   = 0;
    int failures = 0;

    // Reference model: payload queues bounded by DEPTH plus stall counters.
    logic [31:0] exp_q2[$];
    logic [31:0] exp_q1[$];
    int          cnt2;
    int          cnt1;

    typedef struct {
        logic        iv;
        logic [31:0] d;
        logic        ordy;
        logic        fl;
        logic        clr;
        logic        ir;
        logic        ov;
        logic [31:0] od;
        int          cnt;
    } vec_t;

    vec_t tbl[14];

    always #5 clk = ~clk;

    pipe_stage_buffer #(
        .DATA_W(32), .DEPTH(2), .BUBBLE_ZERO(1), .CNT_W(16)
    ) u_d2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready2), .out_valid(out_valid2), .out_data(out_data2),
        .out_ready(out_ready), .flush(flush), .clr_cnt(clr_cnt),
        .stall_cnt(stall_cnt2)
    );

    pipe_stage_buffer #(
        .DATA_W(32), .DEPTH(1), .BUBBLE_ZERO(1), .CNT_W(4)
    ) u_d1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready1), .out_valid(out_valid1), .out_data(out_data1),
        .out_ready(out_ready), .flush(flush), .clr_cnt(clr_cnt),
        .stall_cnt(stall_cnt1)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic model_check();
        chk("d2_in_ready",  {31'd0, in_ready2},  {31'd0, exp_q2.size() < 2});
        chk("d2_out_valid", {31'd0, out_valid2}, {31'd0, exp_q2.size() > 0});
        chk("d2_out_data",  out_data2, (exp_q2.size() > 0) ? exp_q2[0] : 32'h0);
        chk("d2_stall_cnt", {16'd0, stall_cnt2}, cnt2);
        chk("d1_in_ready",  {31'd0, in_ready1},  {31'd0, (exp_q1.size() == 0) || out_ready});
        chk("d1_out_valid", {31'd0, out_valid1}, {31'd0, exp_q1.size() > 0});
        chk("d1_out_data",  out_data1, (exp_q1.size() > 0) ? exp_q1[0] : 32'h0);
        chk("d1_stall_cnt", {28'd0, stall_cnt1}, cnt1);
    endtask

    // Inputs are already applied (just after a falling edge); check, clock, update model.
    task automatic step();
        bit ir2, ov2, ir1, ov1;
        #1;
        model_check();
        ir2 = exp_q2.size() < 2;
        ov2 = exp_q2.size() > 0;
        ir1 = (exp_q1.size() == 0) || out_ready;
        ov1 = exp_q1.size() > 0;
        @(posedge clk);
        if (clr_cnt) cnt2 = 0;
        else if (ov2 && !out_ready && cnt2 < 65535) cnt2++;
        if (clr_cnt) cnt1 = 0;
        else if (ov1 && !out_ready && cnt1 < 15) cnt1++;
        if (flush) begin
            exp_q2.delete();
            exp_q1.delete();
        end else begin
            if (ov2 && out_ready) void'(exp_q2.pop_front());
            if (in_valid && ir2) exp_q2.push_back(in_data);
            if (ov1 && out_ready) void'(exp_q1.pop_front());
            if (in_valid && ir1) exp_q1.push_back(in_data);
        end
        @(negedge clk);
    endtask

    task automatic set_in(input logic iv, input logic [31:0] d, input logic ordy,
                          input logic fl, input logic clr);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        flush     = fl;
        clr_cnt   = clr;
    endtask

    // Asserts reset between edges and checks the outputs clear without a clock.
    task automatic do_reset(input string tag);
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        chk({tag, "_d2_out_valid"}, {31'd0, out_valid2}, 32'h0);
        chk({tag, "_d2_out_data"},  out_data2, 32'h0);
        chk({tag, "_d2_stall_cnt"}, {16'd0, stall_cnt2}, 32'h0);
        chk({tag, "_d1_out_valid"}, {31'd0, out_valid1}, 32'h0);
        chk({tag, "_d1_out_data"},  out_data1, 32'h0);
        chk({tag, "_d1_stall_cnt"}, {28'd0, stall_cnt1}, 32'h0);
        exp_q2.delete();
        exp_q1.delete();
        cnt2 = 0;
        cnt1 = 0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk({tag, "_d2_in_ready"}, {31'd0, in_ready2}, 32'h1);
        chk({tag, "_d1_in_ready"}, {31'd0, in_ready1}, 32'h1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b0;
        cnt2  = 0;
        cnt1  = 0;
        @(negedge clk);
        do_reset("init_rst");
        @(negedge clk);

        // Streaming: one payload per cycle, one cycle latency, no gaps.
        for (int i = 0; i <= 8; i++) begin
            set_in(i < 8, (i < 8) ? 32'h11 + i : 32'h0, 1'b1, 1'b0, 1'b0);
            if (i > 0) begin
                #1;
                chk("stream_valid", {31'd0, out_valid2}, 32'h1);
                chk("stream_data",  out_data2, 32'h10 + i);
            end
            step();
        end
        chk("stream_stall_cnt", {16'd0, stall_cnt2}, 32'h0);

        // Backpressure, flush with simultaneous input, clr_cnt: DEPTH=2 table.
        tbl[0]  = '{1'b1, 32'h0A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 0};
        tbl[1]  = '{1'b1, 32'h0B, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0A, 0};
        tbl[2]  = '{1'b1, 32'h0C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0A, 1};
        tbl[3]  = '{1'b1, 32'h0C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0A, 2};
        tbl[4]  = '{1'b1, 32'h0C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0B, 2};
        tbl[5]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0C, 2};
        tbl[6]  = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 2};
        tbl[7]  = '{1'b1, 32'h21, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 2};
        tbl[8]  = '{1'b1, 32'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h21, 2};
        tbl[9]  = '{1'b1, 32'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h21, 3};
        tbl[10] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 4};
        tbl[11] = '{1'b1, 32'h33, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h00, 4};
        tbl[12] = '{1'b0, 32'h00, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h33, 0};
        tbl[13] = '{1'b0, 32'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h00, 0};
        do_reset("tbl_rst");
        for (int i = 0; i < 14; i++) begin
            set_in(tbl[i].iv, tbl[i].d, tbl[i].ordy, tbl[i].fl, tbl[i].clr);
            #1;
            chk($sformatf("tbl%0d_in_ready", i),  {31'd0, in_ready2},  {31'd0, tbl[i].ir});
            chk($sformatf("tbl%0d_out_valid", i), {31'd0, out_valid2}, {31'd0, tbl[i].ov});
            chk($sformatf("tbl%0d_out_data", i),  out_data2, tbl[i].od);
            chk($sformatf("tbl%0d_stall_cnt", i), {16'd0, stall_cnt2}, tbl[i].cnt);
            step();
        end

        // DEPTH=1: in_ready follows out_ready within the cycle while in ONE.
        set_in(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        step();
        set_in(1'b1, 32'h44, 1'b0, 1'b0, 1'b0);
        step();
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        #1;
        chk("d1_comb_ready_lo", {31'd0, in_ready1}, 32'h0);
        out_ready = 1'b1;
        #1;
        chk("d1_comb_ready_hi", {31'd0, in_ready1}, 32'h1);
        out_ready = 1'b0;
        #1;
        chk("d1_comb_ready_lo2", {31'd0, in_ready1}, 32'h0);
        set_in(1'b1, 32'h55, 1'b1, 1'b0, 1'b0);
        step();
        chk("d1_replace_data",  out_data1, 32'h55);
        chk("d1_replace_valid", {31'd0, out_valid1}, 32'h1);

        // CNT_W=4 saturation and clear priority.
        set_in(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        step();
        clr_cnt = 1'b0;
        for (int i = 0; i < 20; i++) step();
        chk("sat_cnt_15", {28'd0, stall_cnt1}, 32'd15);
        clr_cnt = 1'b1;
        step();
        chk("sat_clr_0", {28'd0, stall_cnt1}, 32'd0);
        clr_cnt = 1'b0;
        step();
        chk("sat_after_clr_1", {28'd0, stall_cnt1}, 32'd1);

        // Mid-stream reset with two payloads held in the DEPTH=2 instance.
        set_in(1'b1, 32'h66, 1'b0, 1'b0, 1'b0);
        step();
        chk("pre_rst_d2_full", {31'd0, in_ready2}, 32'h0);
        do_reset("mid_rst");
        @(negedge clk);

        // Randomised traffic against the reference model.
        for (int i = 0; i < 500; i++) begin
            set_in($urandom_range(0, 3) != 0, $urandom,
                   $urandom_range(0, 2) != 0,
                   $urandom_range(0, 19) == 0,
                   $urandom_range(0, 29) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
